// File: rtl/mic1_pkg.sv
// Shared constants and types for the MIC-1 microsequencer.
package mic1_pkg;

    // Default geometry of the control store and the micro-call stack
    localparam int DEFAULT_ADDR_W      = 9;
    localparam int DEFAULT_MBR_W       = 8;
    localparam int DEFAULT_STACK_DEPTH = 4;

    // Bit positions of the MIR control bits inside the packed control vector
    localparam int MIR_JMPC   = 0;
    localparam int MIR_JAMN   = 1;
    localparam int MIR_JAMZ   = 2;
    localparam int MIR_CALL   = 3;
    localparam int MIR_RET    = 4;
    localparam int MIR_CTRL_W = 5;

    // What the sequencer does with the micro-instruction held in stage 1
    typedef enum logic [2:0] {
        ACT_JUMP,
        ACT_CALL,
        ACT_CALL_OVF,
        ACT_RET,
        ACT_RET_UNF
    } seq_action_e;

endpackage

// File: rtl/mic1_ustack.sv
// Micro-call return stack: LIFO of return addresses with occupancy count.
// Entries are never cleared; the top entry is only read while the stack is non-empty.
module mic1_ustack #(
    parameter int ADDR_W      = 9,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [ADDR_W-1:0]                    din,
    output logic [ADDR_W-1:0]                    dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 full,
    output logic                                 empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - SP_W'(1));

    // Top-of-stack read, forced to zero when there is nothing valid to read
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[top_idx];
        end
    end

    // Occupancy counter; a push into a full stack or a pop from an empty one is a no-op
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (rst && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microprogram sequencer: two-stage pipeline from MIR fields to MPC,
// with JAM/JMPC branching, micro-call/return stack and sticky error flags.
module mic1_sequencer
    import mic1_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int MBR_W       = DEFAULT_MBR_W,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 stall,
    input  logic                                 N,
    input  logic                                 Z,
    input  logic [MBR_W-1:0]                     MBR,
    input  logic [ADDR_W-1:0]                    next_addr,
    input  logic                                 jmpc,
    input  logic                                 jamn,
    input  logic                                 jamz,
    input  logic                                 call,
    input  logic                                 ret,
    output logic [ADDR_W-1:0]                    MPC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 ovf,
    output logic                                 unf,
    output logic                                 ill
);

    // Low part of the address is where MBR gets ORed in; MBR must fit below the top bit
    localparam int LO_W = ADDR_W - 1;

    logic                  n_s;
    logic                  z_s;
    logic [MBR_W-1:0]      mbr_s;
    logic [ADDR_W-1:0]     next_addr_s;
    logic [MIR_CTRL_W-1:0] ctrl_in;
    logic [MIR_CTRL_W-1:0] ctrl_s;

    logic                  hi;
    logic [LO_W-1:0]       lo;
    logic [ADDR_W-1:0]     target;
    seq_action_e           action;

    logic                  stk_push;
    logic                  stk_pop;
    logic [ADDR_W-1:0]     stk_din;
    logic [ADDR_W-1:0]     stk_dout;
    logic                  stk_full;
    logic                  stk_empty;

    assign ctrl_in[MIR_JMPC] = jmpc;
    assign ctrl_in[MIR_JAMN] = jamn;
    assign ctrl_in[MIR_JAMZ] = jamz;
    assign ctrl_in[MIR_CALL] = call;
    assign ctrl_in[MIR_RET]  = ret;

    // Stage 1: capture flags, dispatch byte and MIR fields unless stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_s         <= 1'b0;
            z_s         <= 1'b0;
            mbr_s       <= '0;
            next_addr_s <= '0;
            ctrl_s      <= '0;
        end else if (!stall) begin
            n_s         <= N;
            z_s         <= Z;
            mbr_s       <= MBR;
            next_addr_s <= next_addr;
            ctrl_s      <= ctrl_in;
        end
    end

    // Branch target: JAM bits force the top bit, JMPC ORs the dispatch byte into the rest
    always_comb begin
        hi = next_addr_s[ADDR_W-1]
           | (ctrl_s[MIR_JAMZ] & z_s)
           | (ctrl_s[MIR_JAMN] & n_s);
        lo = next_addr_s[LO_W-1:0];
        if (ctrl_s[MIR_JMPC]) begin
            lo = lo | LO_W'(mbr_s);
        end
        target = {hi, lo};
    end

    // Decide the stage-2 action; a return wins whenever RET is set, even alongside CALL
    always_comb begin
        action = ACT_JUMP;
        if (ctrl_s[MIR_RET]) begin
            action = stk_empty ? ACT_RET_UNF : ACT_RET;
        end else if (ctrl_s[MIR_CALL]) begin
            action = stk_full ? ACT_CALL_OVF : ACT_CALL;
        end
    end

    assign stk_push = rst && !stall && (action == ACT_CALL);
    assign stk_pop  = rst && !stall && (action == ACT_RET);
    assign stk_din  = MPC + ADDR_W'(1);

    mic1_ustack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ustack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Stage 2: load MPC and raise the sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            MPC <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            ill <= 1'b0;
        end else if (!stall) begin
            if (ctrl_s[MIR_CALL] && ctrl_s[MIR_RET]) begin
                ill <= 1'b1;
            end
            unique case (action)
                ACT_JUMP: begin
                    MPC <= target;
                end
                ACT_CALL: begin
                    MPC <= target;
                end
                ACT_CALL_OVF: begin
                    MPC <= target;
                    ovf <= 1'b1;
                end
                ACT_RET: begin
                    MPC <= stk_dout;
                end
                ACT_RET_UNF: begin
                    MPC <= '0;
                    unf <= 1'b1;
                end
                default: begin
                    MPC <= target;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic1_sequencer.sv
// Scoreboard testbench for mic1_sequencer: directed cases plus randomized traffic
// checked against a queue-based behavioural model of the microsequencer.
module tb_mic1_sequencer;

    localparam int ADDR_W = 9;
    localparam int MBR_W  = 8;
    localparam int DEPTH  = 4;
    localparam int SP_W   = 3;
    localparam int AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              N;
    logic              Z;
    logic [MBR_W-1:0]  MBR;
    logic [ADDR_W-1:0] next_addr;
    logic              jmpc;
    logic              jamn;
    logic              jamz;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] MPC;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              unf;
    logic              ill;

    typedef struct {
        bit n, z;
        int mbr, na;
        bit jmpc, jamn, jamz, call, ret;
    } instr_t;

    typedef struct {
        int edge_no;
        int mpc;
        int sp;
        bit ovf, unf, ill;
    } exp_t;

    exp_t   exp_q[$];
    int     edge_count = 0;
    int     checks = 0;
    int     errors = 0;

    // Reference model state
    int     m_mpc = 0;
    int     m_stack[$];
    bit     m_ovf = 0, m_unf = 0, m_ill = 0;
    instr_t m_pipe = '{default: 0};

    mic1_sequencer #(
        .ADDR_W      (ADDR_W),
        .MBR_W       (MBR_W),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .N         (N),
        .Z         (Z),
        .MBR       (MBR),
        .next_addr (next_addr),
        .jmpc      (jmpc),
        .jamn      (jamn),
        .jamz      (jamz),
        .call      (call),
        .ret       (ret),
        .MPC       (MPC),
        .sp        (sp),
        .ovf       (ovf),
        .unf       (unf),
        .ill       (ill)
    );

    // Free-running clock and an edge counter used to line up expectations
    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural step: the state one edge from now, given the inputs being driven
    task automatic modelStep(input bit r, input bit st, input instr_t in);
        int tgt;
        if (!r) begin
            m_mpc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
            m_ill = 0;
            m_pipe = '{default: 0};
        end else if (!st) begin
            tgt = m_pipe.na;
            if (m_pipe.jmpc) tgt = tgt | m_pipe.mbr;
            if ((m_pipe.jamz && m_pipe.z) || (m_pipe.jamn && m_pipe.n)) tgt = tgt | (AMOD / 2);
            if (m_pipe.ret) begin
                if (m_pipe.call) m_ill = 1;
                if (m_stack.size() > 0) begin
                    m_mpc = m_stack.pop_back();
                end else begin
                    m_unf = 1;
                    m_mpc = 0;
                end
            end else if (m_pipe.call) begin
                if (m_stack.size() < DEPTH) m_stack.push_back((m_mpc + 1) % AMOD);
                else m_ovf = 1;
                m_mpc = tgt;
            end else begin
                m_mpc = tgt;
            end
            m_pipe = in;
        end
    endtask

    // Drive one cycle of inputs, record the expected state after the next edge, then advance
    task automatic applyStimulus(input bit r, input bit st, input bit n, input bit z,
                                 input int mbr, input int na, input bit jc, input bit jn,
                                 input bit jz, input bit cl, input bit rt);
        instr_t in;
        exp_t   e;
        rst = r; stall = st; N = n; Z = z;
        MBR = MBR_W'(mbr); next_addr = ADDR_W'(na);
        jmpc = jc; jamn = jn; jamz = jz; call = cl; ret = rt;
        in = '{n: n, z: z, mbr: mbr % (1 << MBR_W), na: na % AMOD,
               jmpc: jc, jamn: jn, jamz: jz, call: cl, ret: rt};
        modelStep(r, st, in);
        e = '{edge_no: edge_count + 1, mpc: m_mpc, sp: m_stack.size(),
              ovf: m_ovf, unf: m_unf, ill: m_ill};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic doNop();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the DUT against every expectation due at this edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_count) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("mpc@%0d", e.edge_no), 32'(MPC), e.mpc);
                checkOutput($sformatf("sp@%0d", e.edge_no), 32'(sp), e.sp);
                checkOutput($sformatf("flags@%0d", e.edge_no), 32'({ovf, unf, ill}),
                            {29'd0, e.ovf, e.unf, e.ill});
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int addrs[5];
        addrs = '{'h020, 'h040, 'h060, 'h080, 'h0A0};

        doReset();
        checkOutput("reset_mpc", 32'(MPC), 0);
        checkOutput("reset_sp", 32'(sp), 0);
        checkOutput("reset_flags", 32'({ovf, unf, ill}), 0);

        applyStimulus(1, 0, 0, 0, 0, 'h1FF, 0, 0, 0, 0, 0);
        doNop();
        checkOutput("full_addr", 32'(MPC), 'h1FF);

        applyStimulus(1, 0, 1, 0, 0, 'h000, 0, 1, 0, 0, 0);
        doNop();
        checkOutput("jamn", 32'(MPC), 'h100);

        applyStimulus(1, 0, 0, 1, 0, 'h000, 0, 0, 1, 0, 0);
        doNop();
        checkOutput("jamz", 32'(MPC), 'h100);

        applyStimulus(1, 0, 0, 0, 'h5A, 'h000, 1, 0, 0, 0, 0);
        doNop();
        checkOutput("jmpc_lo", 32'(MPC), 'h05A);

        applyStimulus(1, 0, 0, 0, 'h5A, 'h100, 1, 0, 0, 0, 0);
        doNop();
        checkOutput("jmpc_hi", 32'(MPC), 'h15A);

        doReset();
        applyStimulus(1, 0, 0, 0, 0, 'h010, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 'h080, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 'h000, 0, 0, 0, 0, 1);
        checkOutput("call_mpc", 32'(MPC), 'h080);
        checkOutput("call_sp", 32'(sp), 1);
        doNop();
        checkOutput("ret_mpc", 32'(MPC), 'h011);
        checkOutput("ret_sp", 32'(sp), 0);

        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, addrs[i], 0, 0, 0, 1, 0);
        checkOutput("nest_mpc", 32'(MPC), 'h080);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 1, 1, $urandom_range(0, 255), $urandom_range(0, 511), 1, 1, 1, 1, 1);
        checkOutput("stall_mpc", 32'(MPC), 'h080);
        checkOutput("stall_sp", 32'(sp), 4);
        checkOutput("stall_ovf", 32'(ovf), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            if (i == 0) begin
                checkOutput("ovf_set", 32'(ovf), 1);
                checkOutput("ovf_sp", 32'(sp), 4);
                checkOutput("ovf_mpc", 32'(MPC), 'h0A0);
            end
        end
        doNop();
        checkOutput("unf_mpc", 32'(MPC), 0);
        checkOutput("unf_set", 32'(unf), 1);
        checkOutput("unf_sp", 32'(sp), 0);

        applyStimulus(1, 0, 0, 0, 0, 'h033, 0, 0, 0, 1, 1);
        doNop();
        checkOutput("ill_set", 32'(ill), 1);

        // Wrap of the return address from the all-ones location
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 'h1FF, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 'h044, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        doNop();
        checkOutput("wrap_mpc", 32'(MPC), 0);
        checkOutput("wrap_unf", 32'(unf), 0);

        // Randomized traffic, including resets and stalls at arbitrary points
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 4) == 0,
                          1'($urandom), 1'($urandom), $urandom_range(0, 255),
                          $urandom_range(0, 511), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        doNop();
        doNop();
        @(posedge clk);
        #5;
        checkOutput("drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
